// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among
// NUM_REQ writeback sources; one registered write per cycle, index 0 suppressed.
`timescale 1ns/1ps

module rf_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write_enabled,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [1:0]                last_grant,
  output logic [15:0]               conflict_count
);

  logic [1:0]         ptr;
  logic [1:0]         next_ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [1:0]         grant_idx;
  logic               grant_found;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               conflict;

  // Search starts at ptr and wraps; only req_valid and ptr steer the grant.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req_valid[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_REQ))) begin
          grant_found = 1'b1;
          grant_idx   = 2'(i);
          grant_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr  = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
  assign conflict  = ($countones(req_valid) >= 2);
  assign req_ready = grant_oh;

  // A grant is only issued to a valid requester, so grant_found is the transfer.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr              <= '0;
      last_grant       <= '0;
      rf_write_enabled <= 1'b0;
      rf_write_addr    <= '0;
      rf_write_data    <= '0;
    end else begin
      rf_write_enabled <= 1'b0;
      if (grant_found) begin
        ptr              <= next_ptr;
        last_grant       <= grant_idx;
        rf_write_addr    <= sel_addr;
        rf_write_data    <= sel_data;
        rf_write_enabled <= (sel_addr != '0);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict_count <= '0;
    end else if (conflict && (conflict_count != 16'hFFFF)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a spec-level model compared every
// falling edge, plus directed vectors with hand-computed literal expectations.
`timescale 1ns/1ps

module tb_rf_write_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            rf_write_enabled;
  logic [AW-1:0]   rf_write_addr;
  logic [DW-1:0]   rf_write_data;
  logic [1:0]      last_grant;
  logic [15:0]     conflict_count;

  rf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rf_write_enabled (rf_write_enabled),
    .rf_write_addr    (rf_write_addr),
    .rf_write_data    (rf_write_data),
    .last_grant       (last_grant),
    .conflict_count   (conflict_count)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Spec-level model: pointer, last winner, pending write and conflict tally.
  int          m_ptr  = 0;
  int          m_last = 0;
  int          m_cnt  = 0;
  bit          m_en   = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] tb_rf [32];

  task automatic model_reset();
    m_ptr = 0; m_last = 0; m_cnt = 0; m_en = 0; m_addr = '0; m_data = '0;
  endtask

  always @(negedge reset_n) model_reset();

  always @(negedge clock) begin
    if (!reset_n) begin
      model_reset();
      check("reset_we",   32'(rf_write_enabled), 32'd0);
      check("reset_addr", 32'(rf_write_addr),    32'd0);
      check("reset_cnt",  32'(conflict_count),   32'd0);
    end else begin
      int w;
      int nv;
      logic [N-1:0] exp_ready;
      w = -1;
      nv = 0;
      exp_ready = '0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req_valid[c]) w = c;
        if (req_valid[k]) nv++;
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      check("m_ready", 32'(req_ready),        32'(exp_ready));
      check("m_we",    32'(rf_write_enabled), 32'(m_en));
      check("m_addr",  32'(rf_write_addr),    m_addr);
      check("m_data",  32'(rf_write_data),    m_data);
      check("m_last",  32'(last_grant),       32'(m_last));
      check("m_cnt",   32'(conflict_count),   32'(m_cnt));
      if (rf_write_enabled) tb_rf[rf_write_addr] = rf_write_data;
      if (nv >= 2 && m_cnt < 65535) m_cnt++;
      m_en = 0;
      if (w >= 0) begin
        m_addr = 32'(req_addr[w*AW +: AW]);
        m_data = req_data[w*DW +: DW];
        m_en   = (m_addr != 0);
        m_last = w;
        m_ptr  = (w + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    #1 reset_n = 1'b0;

    // 1: reset with both valid, then first grant goes to requester 0
    set_req(0, 1'b1, 5'd3, 32'h3333);
    set_req(1, 1'b1, 5'd4, 32'h4444);
    repeat (2) tick();
    check("t1_we_in_reset", 32'(rf_write_enabled), 32'd0);
    check("t1_cnt_in_reset", 32'(conflict_count), 32'd0);
    reset_n = 1'b1;
    #1 check("t1_first_ready", 32'(req_ready), 32'b01);
    tick();
    check("t1_addr0", 32'(rf_write_addr), 32'd3);
    check("t1_ready1", 32'(req_ready), 32'b10);
    tick();
    check("t1_addr1", 32'(rf_write_addr), 32'd4);
    check("t1_last1", 32'(last_grant), 32'd1);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);

    // 2: single write from requester 0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("t2_ready", 32'(req_ready), 32'b01);
    tick();
    check("t2_we", 32'(rf_write_enabled), 32'd1);
    check("t2_addr", 32'(rf_write_addr), 32'd5);
    check("t2_data", rf_write_data, 32'hDEADBEEF);
    set_req(0, 1'b0, 5'd5, 32'hDEADBEEF);
    tick();
    check("t2_we_off", 32'(rf_write_enabled), 32'd0);
    check("t2_addr_hold", 32'(rf_write_addr), 32'd5);

    // 3: both valid -> grants 0,1,0,1, back-to-back writes, three conflict cycles
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    #1 check("t3_ready_a", 32'(req_ready), 32'b01);
    tick();
    check("t3_w1", 32'(rf_write_addr), 32'd1);
    check("t3_ready_b", 32'(req_ready), 32'b10);
    tick();
    check("t3_w2", 32'(rf_write_addr), 32'd2);
    check("t3_ready_c", 32'(req_ready), 32'b01);
    tick();
    check("t3_w3", 32'(rf_write_addr), 32'd1);
    check("t3_we3", 32'(rf_write_enabled), 32'd1);
    set_req(0, 1'b0, 5'd1, 32'h11);
    #1 check("t3_ready_d", 32'(req_ready), 32'b10);
    tick();
    check("t3_w4", 32'(rf_write_addr), 32'd2);
    check("t3_we4", 32'(rf_write_enabled), 32'd1);
    check("t3_cnt", 32'(conflict_count), 32'd3);
    set_req(1, 1'b0, 5'd2, 32'h22);

    // 4: destination index 0 is accepted but never written
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1 check("t4_ready", 32'(req_ready), 32'b10);
    tick();
    check("t4_last", 32'(last_grant), 32'd1);
    check("t4_we", 32'(rf_write_enabled), 32'd0);
    check("t4_data", rf_write_data, 32'h1234);
    set_req(1, 1'b0, 5'd0, 32'h1234);

    // 5: same index from both with ptr=1 -> BBBB then AAAA, AAAA survives
    set_req(0, 1'b1, 5'd9, 32'h99);
    tick();
    set_req(0, 1'b1, 5'd7, 32'hAAAA);
    set_req(1, 1'b1, 5'd7, 32'hBBBB);
    #1 check("t5_ready_a", 32'(req_ready), 32'b10);
    tick();
    check("t5_data_b", rf_write_data, 32'hBBBB);
    set_req(1, 1'b0, 5'd7, 32'hBBBB);
    #1 check("t5_ready_b", 32'(req_ready), 32'b01);
    tick();
    check("t5_data_a", rf_write_data, 32'hAAAA);
    set_req(0, 1'b0, 5'd7, 32'hAAAA);
    tick();
    check("t5_rf7", tb_rf[7], 32'hAAAA);

    // 6: saturation, then asynchronous reset in the middle of a write
    set_req(0, 1'b1, 5'd3, 32'hC0);
    set_req(1, 1'b1, 5'd4, 32'hC1);
    repeat (65540) tick();
    check("t6_sat", 32'(conflict_count), 32'hFFFF);
    #2 check("t6_we_before", 32'(rf_write_enabled), 32'd1);
    reset_n = 1'b0;
    #1 check("t6_we_async", 32'(rf_write_enabled), 32'd0);
    check("t6_cnt_async", 32'(conflict_count), 32'd0);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    repeat (2) tick();
    check("t6_we_held", 32'(rf_write_enabled), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("t6_we_after", 32'(rf_write_enabled), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
